rom256_burst_arbiter: RTL and testbench

Two-port round-robin arbiter and burst sequencer for the 256×8 OpenROM read macro (`sky130_rom_256`, registered address/chip-select, data valid by the following rising edge). It accepts burst read requests from two independent requesters (A and B), grants the ROM to one at a time, and issues one ROM read per cycle with address auto-increment. It returns tagged read data to the owning requester. It sits between the design's consumers, such as a pattern player and a lookup engine, and the single ROM macro instance.

---
 rtl/rom256_burst_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rom256_burst_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom256_burst_arbiter.sv
// rom256_burst_arbiter
//   Two-requester round-robin arbiter and burst sequencer for a 256x8 ROM
//   macro with a registered address and chip select. The ROM has data valid by
//   the following rising edge. A granted burst issues one ROM read per cycle
//   with a wrapping address. Each issued beat carries a {owner, last} tag down a
//   two-stage pipeline. At stage 2 the ROM data is captured into the owner's
//   response port.
//
// Ports
//   clk0, rst0            clock (also the ROM clock), synchronous active-high reset
//   rq{a,b}_valid/ready   burst request handshake; ready is combinational in IDLE
//   rq{a,b}_addr/len      burst start address, beats minus one
//   rs{a,b}_valid         one-cycle beat strobe, no backpressure
//   rs{a,b}_data/last     beat data (held between beats), final-beat flag
//   rom_cs0, rom_addr0    ROM chip select and address
//   rom_dout0             ROM read data
//   busy                  issuing, or a response beat still in the tag pipeline

// Per-requester response register. Data is loaded only on a strobe, so ROM
// output values outside the capture cycle never reach the port.
module rom256_rs_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  i_stb,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);
  always_ff @(posedge clk0) begin
    if (rst0) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= i_stb;
      o_last  <= i_stb & i_last;
      if (i_stb) o_data <= i_data;
    end
  end
endmodule

module rom256_burst_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  rqa_valid,
  output logic                  rqa_ready,
  input  logic [ADDR_WIDTH-1:0] rqa_addr,
  input  logic [LEN_WIDTH-1:0]  rqa_len,
  input  logic                  rqb_valid,
  output logic                  rqb_ready,
  input  logic [ADDR_WIDTH-1:0] rqb_addr,
  input  logic [LEN_WIDTH-1:0]  rqb_len,
  output logic                  rsa_valid,
  output logic [DATA_WIDTH-1:0] rsa_data,
  output logic                  rsa_last,
  output logic                  rsb_valid,
  output logic [DATA_WIDTH-1:0] rsb_data,
  output logic                  rsb_last,
  output logic                  rom_cs0,
  output logic [ADDR_WIDTH-1:0] rom_addr0,
  input  logic [DATA_WIDTH-1:0] rom_dout0,
  output logic                  busy
);
  localparam int NUM_LANES = 2;
  // Stage 1: ROM has latched the address; stage 2: data captured into a lane.
  localparam int STAGES    = 2;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
  } req_t;

  typedef struct packed {
    logic owner;  // 0 = A, 1 = B
    logic last;
  } tag_t;

  state_t                r_state, w_state_nxt;
  logic                  r_prio;      // requester that wins a tie: 0 = A, 1 = B
  logic                  r_owner;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_rem;       // beats left after the current one
  logic [STAGES:1]       r_vld_pipe;
  tag_t                  r_tag1;

  logic w_win_a, w_win_b, w_hs, w_issue, w_last_beat;
  req_t w_req;

  logic [NUM_LANES-1:0]                 w_lane_stb;
  logic [NUM_LANES-1:0]                 w_rs_valid;
  logic [NUM_LANES-1:0]                 w_rs_last;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] w_rs_data;

  // Priority only matters on a tie; a lone requester always wins.
  assign w_win_a = rqa_valid & (~rqb_valid | ~r_prio);
  assign w_win_b = rqb_valid & (~rqa_valid |  r_prio);
  assign w_req   = w_win_b ? req_t'{rqb_addr, rqb_len} : req_t'{rqa_addr, rqa_len};
  assign w_hs    = rqa_ready | rqb_ready;

  always_comb begin
    w_state_nxt = r_state;
    rqa_ready   = 1'b0;
    rqb_ready   = 1'b0;
    w_issue     = 1'b0;
    w_last_beat = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready held low while in reset so nothing looks accepted.
        if (!rst0) begin
          rqa_ready = w_win_a;
          rqb_ready = w_win_b;
          if (w_win_a | w_win_b) w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue     = 1'b1;
        w_last_beat = (r_rem == '0);
        if (w_last_beat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state    <= S_IDLE;
      r_prio     <= 1'b0;
      r_owner    <= 1'b0;
      r_cur_addr <= '0;
      r_rem      <= '0;
      r_vld_pipe <= '0;
      r_tag1     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_cur_addr <= w_req.addr;
        r_rem      <= w_req.len;
        r_owner    <= w_win_b;
        r_prio     <= ~w_win_b;
      end else if (w_issue) begin
        r_cur_addr <= r_cur_addr + 1'b1;  // wraps naturally at 2^ADDR_WIDTH
        r_rem      <= r_rem - 1'b1;
      end
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_issue};
      r_tag1     <= tag_t'{r_owner, w_last_beat};
    end
  end

  assign rom_cs0   = w_issue;
  assign rom_addr0 = w_issue ? r_cur_addr : '0;
  assign busy      = w_issue | (|r_vld_pipe);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_lane_stb[l] = r_vld_pipe[1] & (r_tag1.owner == 1'(l));
    rom256_rs_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk0    (clk0),
      .rst0    (rst0),
      .i_stb   (w_lane_stb[l]),
      .i_last  (r_tag1.last),
      .i_data  (rom_dout0),
      .o_valid (w_rs_valid[l]),
      .o_data  (w_rs_data[l]),
      .o_last  (w_rs_last[l])
    );
  end

  assign rsa_valid = w_rs_valid[0];
  assign rsa_data  = w_rs_data[0];
  assign rsa_last  = w_rs_last[0];
  assign rsb_valid = w_rs_valid[1];
  assign rsb_data  = w_rs_data[1];
  assign rsb_last  = w_rs_last[1];
endmodule

// File: tb/tb_rom256_burst_arbiter.sv
// Bench for rom256_burst_arbiter: behavioural ROM, cycle-arithmetic model of
// grants/issue windows, and a per-port beat scoreboard checked by a monitor.
module tb_rom256_burst_arbiter;
  localparam int AW = 8, DW = 8, LW = 4;

  logic          clk0 = 1'b0, rst0;
  logic          rqa_valid, rqa_ready, rqb_valid, rqb_ready;
  logic [AW-1:0] rqa_addr, rqb_addr;
  logic [LW-1:0] rqa_len, rqb_len;
  logic          rsa_valid, rsa_last, rsb_valid, rsb_last;
  logic [DW-1:0] rsa_data, rsb_data;
  logic          rom_cs0, busy;
  logic [AW-1:0] rom_addr0;
  logic [DW-1:0] rom_dout0 = '0;

  rom256_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk0(clk0), .rst0(rst0),
    .rqa_valid(rqa_valid), .rqa_ready(rqa_ready), .rqa_addr(rqa_addr), .rqa_len(rqa_len),
    .rqb_valid(rqb_valid), .rqb_ready(rqb_ready), .rqb_addr(rqb_addr), .rqb_len(rqb_len),
    .rsa_valid(rsa_valid), .rsa_data(rsa_data), .rsa_last(rsa_last),
    .rsb_valid(rsb_valid), .rsb_data(rsb_data), .rsb_last(rsb_last),
    .rom_cs0(rom_cs0), .rom_addr0(rom_addr0), .rom_dout0(rom_dout0), .busy(busy)
  );

  always #5 clk0 = ~clk0;

  int cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  // ROM: address registered on the edge, data valid afterwards; junk when idle.
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  always @(posedge clk0) rom_dout0 <= rom_cs0 ? mem[rom_addr0] : 8'($urandom);

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Reference model state
  typedef struct { logic [7:0] d; bit last; int c; } beat_t;
  beat_t q [2][$];
  bit    m_prio = 1'b0;                  // 0: A wins ties
  int    iss_start = 0, iss_end = -1, iss_addr = 0;
  int    busy_start = 0, busy_end = -1;
  int    d_hs_cyc [$];                   // handshakes observed on the DUT
  bit    d_hs_own [$];

  always @(negedge clk0) begin
    int c, L, a0, ln;
    bit ia, ib, exp_cs, v, l;
    logic [7:0] exp_addr, d;
    beat_t e;
    c        = cyc;
    exp_cs   = (c >= iss_start) && (c <= iss_end);
    exp_addr = exp_cs ? 8'(iss_addr + c - iss_start) : 8'h00;
    ia = !rst0 && !exp_cs && rqa_valid && (!rqb_valid || !m_prio);
    ib = !rst0 && !exp_cs && rqb_valid && (!rqa_valid ||  m_prio);
    chk("rqa_ready", 32'(rqa_ready), 32'(ia));
    chk("rqb_ready", 32'(rqb_ready), 32'(ib));
    chk("rom_cs0",   32'(rom_cs0),   32'(exp_cs));
    chk("rom_addr0", 32'(rom_addr0), 32'(exp_addr));
    chk("busy",      32'(busy),      32'((c >= busy_start) && (c <= busy_end)));
    if (rqa_valid && rqa_ready) begin d_hs_cyc.push_back(c); d_hs_own.push_back(1'b0); end
    if (rqb_valid && rqb_ready) begin d_hs_cyc.push_back(c); d_hs_own.push_back(1'b1); end
    if (rsa_valid || rsb_valid) chk("rs_both_valid", 32'(rsa_valid && rsb_valid), 0);
    for (int p = 0; p < 2; p++) begin
      v = p ? rsb_valid : rsa_valid;
      d = p ? rsb_data  : rsa_data;
      l = p ? rsb_last  : rsa_last;
      while (q[p].size() > 0 && q[p][0].c < c) begin
        chk(p ? "rsb_missing_beat" : "rsa_missing_beat", c, q[p][0].c);
        void'(q[p].pop_front());
      end
      if (v) begin
        if (q[p].size() == 0) chk(p ? "rsb_unexpected" : "rsa_unexpected", 1, 0);
        else begin
          e = q[p].pop_front();
          chk(p ? "rsb_data" : "rsa_data", 32'(d), 32'(e.d));
          chk(p ? "rsb_last" : "rsa_last", 32'(l), 32'(e.last));
          chk(p ? "rsb_cycle" : "rsa_cycle", c, e.c);
        end
      end
    end
    if (ia || ib) begin
      a0 = ia ? int'(rqa_addr) : int'(rqb_addr);
      ln = ia ? int'(rqa_len)  : int'(rqb_len);
      L  = ln + 1;
      iss_start = c + 1; iss_end = c + L; iss_addr = a0;
      if (c > busy_end) busy_start = c + 1;
      busy_end = c + L + 2;
      for (int k = 0; k < L; k++) begin
        e.d = mem[8'(a0 + k)]; e.last = (k == ln); e.c = c + 3 + k;
        q[ib].push_back(e);
      end
      m_prio = ia;
    end
    if (rst0) begin
      q[0].delete(); q[1].delete();
      iss_start = 0; iss_end = -1; busy_start = 0; busy_end = -1; m_prio = 1'b0;
    end
  end

  task automatic drive_a(input logic [7:0] a, input logic [3:0] l);
    int n = 0;
    rqa_valid = 1'b1; rqa_addr = a; rqa_len = l;
    do begin @(negedge clk0); n++; end while (!rqa_ready && n < 300);
    if (!rqa_ready) chk("rqa_handshake_timeout", 0, 1);
    @(posedge clk0); #1;
    rqa_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] a, input logic [3:0] l);
    int n = 0;
    rqb_valid = 1'b1; rqb_addr = a; rqb_len = l;
    do begin @(negedge clk0); n++; end while (!rqb_ready && n < 300);
    if (!rqb_ready) chk("rqb_handshake_timeout", 0, 1);
    @(posedge clk0); #1;
    rqb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk0); n++;
      done = (cyc > busy_end) && (cyc > iss_end) && q[0].size() == 0 && q[1].size() == 0;
    end
    if (!done) chk("wait_idle_timeout", 0, 1);
    @(posedge clk0); #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk0); #1 rst0 = 1'b1;
    repeat (n) @(posedge clk0);
    #1 rst0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int n0;
    rst0 = 1'b1;
    rqa_valid = 1'b0; rqa_addr = '0; rqa_len = '0;
    rqb_valid = 1'b0; rqb_addr = '0; rqb_len = '0;
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    chk("reset_rsa_data",  32'(rsa_data),  0);
    chk("reset_rsb_data",  32'(rsb_data),  0);
    chk("reset_rsa_last",  32'(rsa_last),  0);
    chk("reset_rsb_last",  32'(rsb_last),  0);
    chk("reset_rsa_valid", 32'(rsa_valid), 0);
    @(posedge clk0); #1 rst0 = 1'b0;

    // Single beat on A, then a wrapping burst on B
    drive_a(8'h10, 4'd0); wait_idle();
    drive_b(8'hFE, 4'd3); wait_idle();

    // Contention from reset: A, B, A with handshakes 3 cycles apart
    do_reset(1);
    n0 = d_hs_cyc.size();
    fork
      begin drive_a(8'($urandom), 4'd1); drive_a(8'($urandom), 4'd1); end
      drive_b(8'($urandom), 4'd1);
    join
    wait_idle();
    chk("cont_grants", 32'(d_hs_cyc.size() - n0), 3);
    if (d_hs_cyc.size() - n0 >= 3) begin
      chk("cont_own0", 32'(d_hs_own[n0]),   0);
      chk("cont_own1", 32'(d_hs_own[n0+1]), 1);
      chk("cont_own2", 32'(d_hs_own[n0+2]), 0);
      chk("cont_gap1", d_hs_cyc[n0+1] - d_hs_cyc[n0],   3);
      chk("cont_gap2", d_hs_cyc[n0+2] - d_hs_cyc[n0+1], 3);
    end

    // Long A burst, B queued one cycle later: B handshake 17 cycles after A
    n0 = d_hs_cyc.size();
    fork
      drive_a(8'($urandom), 4'd15);
      begin @(posedge clk0); #1; drive_b(8'($urandom), 4'd0); end
    join
    wait_idle();
    chk("ovl_grants", 32'(d_hs_cyc.size() - n0), 2);
    if (d_hs_cyc.size() - n0 >= 2) begin
      chk("ovl_own_b", 32'(d_hs_own[n0+1]), 1);
      chk("ovl_gap",   d_hs_cyc[n0+1] - d_hs_cyc[n0], 17);
    end

    // Reset mid-burst: A len=7, reset during cycle 4; priority returns to A
    drive_a(8'($urandom), 4'd7);
    repeat (3) @(posedge clk0);
    #1 rst0 = 1'b1;
    @(posedge clk0); #1 rst0 = 1'b0;
    repeat (8) @(posedge clk0);
    #1;
    n0 = d_hs_cyc.size();
    fork
      drive_a(8'($urandom), 4'($urandom));
      drive_b(8'($urandom), 4'($urandom));
    join
    wait_idle();
    chk("rst_grants", 32'(d_hs_cyc.size() - n0), 2);
    if (d_hs_cyc.size() - n0 >= 1) chk("rst_first_own_a", 32'(d_hs_own[n0]), 0);

    // Random traffic from both requesters
    fork
      repeat (15) begin
        repeat ($urandom_range(0, 4)) @(posedge clk0);
        #1; drive_a(8'($urandom), 4'($urandom));
      end
      repeat (15) begin
        repeat ($urandom_range(0, 4)) @(posedge clk0);
        #1; drive_b(8'($urandom), 4'($urandom));
      end
    join
    wait_idle();
    repeat (4) @(posedge clk0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
